// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - shared encodings for the multi-cycle MIPS-subset control path
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_SLT   = 3'd3,
        ALU_LUI   = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RS     = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_RT     = 2'd0,
        SRCB_FOUR   = 2'd1,
        SRCB_IMM    = 2'd2,
        SRCB_IMM_SH = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        DST_RT  = 2'd0,
        DST_RD  = 2'd1,
        DST_R31 = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'd0,
        M2R_MDR    = 2'd1,
        M2R_PC     = 2'd2
    } mem_to_reg_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// rtl/mc_mem_wait.sv - per-access wait-state counter with timeout flag
module mc_mem_wait #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic rdy_i,
    output logic timeout_o
);

    logic [7:0] wait_cnt;

    // Idle or completed access leaves the counter at zero, so every new access starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i || !req_i || rdy_i) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 8'(MEM_TIMEOUT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A ready in the cycle the limit is reached still completes the access.
    assign timeout_o = req_i && !rdy_i && (wait_cnt == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_cpu_ctrl.sv
// rtl/mc_cpu_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with retire counter
module mc_cpu_ctrl
    import mc_cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_rdy_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             reg_we_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             done_o,
    output logic             err_o,
    output logic [RET_W-1:0] retired_o
);

    state_t     state;
    state_t     state_nx;
    logic [5:0] op_q;
    logic       access;
    logic       timeout;
    logic [1:0] ex_src_b;
    logic [2:0] ex_alu_op;

    assign access = (state == S_FETCH) || (state == S_MEM);

    mc_mem_wait #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (access),
        .rdy_i    (mem_rdy_i),
        .timeout_o(timeout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_FETCH;
            op_q      <= '0;
            retired_o <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                op_q <= opcode_i;
            end
            if (done_o) begin
                retired_o <= retired_o + RET_W'(1);
            end
        end
    end

    // The EXEC ALU setup is held through MEM and WB so ALUOut keeps the address/result.
    always_comb begin
        ex_src_b  = SRCB_IMM;
        ex_alu_op = ALU_ADD;
        case (op_q)
            OP_RTYPE: begin
                ex_src_b  = SRCB_RT;
                ex_alu_op = ALU_FUNCT;
            end
            OP_BEQ, OP_BNE: begin
                ex_src_b  = SRCB_RT;
                ex_alu_op = ALU_SUB;
            end
            OP_SLTI: ex_alu_op = ALU_SLT;
            OP_LUI:  ex_alu_op = ALU_LUI;
            default: ;
        endcase
    end

    always_comb begin
        state_nx     = state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = PC_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        alu_op_o     = ALU_ADD;
        reg_we_o     = 1'b0;
        reg_dst_o    = DST_RT;
        mem_to_reg_o = M2R_ALUOUT;
        done_o       = 1'b0;
        err_o        = 1'b0;

        // While reset is held every output stays quiet, abandoning any in-flight access.
        if (!rst_i) begin
            case (state)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = SRCB_FOUR;
                    ir_we_o     = mem_rdy_i;
                    pc_we_o     = mem_rdy_i;
                    if (mem_rdy_i) begin
                        state_nx = S_DECODE;
                    end else if (timeout) begin
                        state_nx = S_ERR;
                    end
                end
                S_DECODE: begin
                    alu_src_b_o = SRCB_IMM_SH;
                    if (!is_legal_op(opcode_i)) begin
                        state_nx = S_ERR;
                    end else if (opcode_i == OP_J || opcode_i == OP_JAL) begin
                        pc_we_o  = 1'b1;
                        pc_src_o = PC_JUMP;
                        done_o   = 1'b1;
                        state_nx = S_FETCH;
                        if (opcode_i == OP_JAL) begin
                            reg_we_o     = 1'b1;
                            reg_dst_o    = DST_R31;
                            mem_to_reg_o = M2R_PC;
                        end
                    end else if (opcode_i == OP_RTYPE && funct_i == FN_JR) begin
                        pc_we_o  = 1'b1;
                        pc_src_o = PC_RS;
                        done_o   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ex_src_b;
                    alu_op_o    = ex_alu_op;
                    case (op_q)
                        OP_BEQ, OP_BNE: begin
                            pc_src_o = PC_ALUOUT;
                            pc_we_o  = zero_i ^ (op_q == OP_BNE);
                            done_o   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        OP_LW, OP_SW: state_nx = S_MEM;
                        default:      state_nx = S_WB;
                    endcase
                end
                S_MEM: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ex_src_b;
                    alu_op_o    = ex_alu_op;
                    mem_req_o   = 1'b1;
                    iord_o      = 1'b1;
                    mem_we_o    = (op_q == OP_SW);
                    if (mem_rdy_i) begin
                        if (op_q == OP_SW) begin
                            done_o   = 1'b1;
                            state_nx = S_FETCH;
                        end else begin
                            state_nx = S_WB;
                        end
                    end else if (timeout) begin
                        state_nx = S_ERR;
                    end
                end
                S_WB: begin
                    alu_src_a_o  = 1'b1;
                    alu_src_b_o  = ex_src_b;
                    alu_op_o     = ex_alu_op;
                    reg_we_o     = 1'b1;
                    reg_dst_o    = (op_q == OP_RTYPE) ? DST_RD : DST_RT;
                    mem_to_reg_o = (op_q == OP_LW) ? M2R_MDR : M2R_ALUOUT;
                    done_o       = 1'b1;
                    state_nx     = S_FETCH;
                end
                S_ERR: begin
                    err_o = 1'b1;
                end
                default: begin
                    state_nx = S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// tb/tb_mc_cpu_ctrl.sv - randomized self-checking bench for mc_cpu_ctrl
module tb_mc_cpu_ctrl;

    localparam int MT = 4;
    localparam int RW = 4;

    localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04;
    localparam logic [5:0] T_BNE = 6'h05, T_ADDI = 6'h08, T_SLTI = 6'h0A, T_LUI = 6'h0F;
    localparam logic [5:0] T_LW = 6'h23, T_SW = 6'h2B;
    localparam int K_JMP = 0, K_BR = 1, K_ALU = 2, K_SW = 3, K_LW = 4, K_ILL = 5;

    localparam logic [19:0] M_ALL   = 20'hFFFFF;
    localparam logic [19:0] M_NOALU = 20'hFE07F;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_a;
        logic [1:0] alu_b;
        logic [2:0] alu_op;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] m2r;
        logic       done;
        logic       err;
    } ovec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, rdy = 1'b0, zero = 1'b0;
    logic [5:0]    opcode = '0, funct = '0;
    logic          mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, reg_we, done, err;
    logic [1:0]    pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [2:0]    alu_op;
    logic [RW-1:0] retired;

    mc_cpu_ctrl #(.MEM_TIMEOUT(MT), .RET_W(RW)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
        .mem_rdy_i(rdy), .mem_req_o(mem_req), .mem_we_o(mem_we), .iord_o(iord),
        .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .reg_we_o(reg_we), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .done_o(done), .err_o(err), .retired_o(retired)
    );

    logic [19:0] act_v;
    assign act_v = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                    alu_op, reg_we, reg_dst, mem_to_reg, done, err};

    int            total = 0, bad = 0, ncyc = 0;
    logic          chk_en = 1'b0, prev_rst = 1'b1, prev_done = 1'b0;
    logic [19:0]   exp_v = '0, mask = '0;
    logic [RW-1:0] ret_m = '0, exp_ret = '0;
    string         tag = "idle";
    ovec_t         snap [0:31];
    logic [RW-1:0] snap_ret [0:31];

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ((act_v & mask) !== (exp_v & mask)) begin
                bad++;
                $display("FAIL %s outputs t=%0t got=%h want=%h", tag, $time, act_v & mask, exp_v & mask);
            end
            total++;
            if (retired !== exp_ret) begin
                bad++;
                $display("FAIL %s retired t=%0t got=%0d want=%0d", tag, $time, retired, exp_ret);
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic int klass(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            T_R:                    return (fn == 6'h08) ? K_JMP : K_ALU;
            T_J, T_JAL:             return K_JMP;
            T_BEQ, T_BNE:           return K_BR;
            T_ADDI, T_SLTI, T_LUI:  return K_ALU;
            T_SW:                   return K_SW;
            T_LW:                   return K_LW;
            default:                return K_ILL;
        endcase
    endfunction

    function automatic int base_lat(input int k);
        case (k)
            K_JMP:   return 2;
            K_BR:    return 3;
            K_LW:    return 5;
            default: return 4;
        endcase
    endfunction

    function automatic ovec_t f_fetch(input logic r);
        ovec_t v = '0;
        v.mem_req = 1'b1; v.ir_we = r; v.pc_we = r; v.alu_b = 2'd1;
        return v;
    endfunction

    function automatic ovec_t f_decode(input logic [5:0] op, input logic [5:0] fn);
        ovec_t v = '0;
        v.alu_b = 2'd3;
        if (op == T_J || op == T_JAL) begin
            v.pc_we = 1'b1; v.pc_src = 2'd2; v.done = 1'b1;
            if (op == T_JAL) begin
                v.reg_we = 1'b1; v.reg_dst = 2'd2; v.m2r = 2'd2;
            end
        end else if (op == T_R && fn == 6'h08) begin
            v.pc_we = 1'b1; v.pc_src = 2'd3; v.done = 1'b1;
        end
        return v;
    endfunction

    function automatic ovec_t f_exec(input logic [5:0] op, input logic z);
        ovec_t v = '0;
        v.alu_a = 1'b1;
        v.alu_b = 2'd2;
        if (op == T_R) begin
            v.alu_b = 2'd0; v.alu_op = 3'd2;
        end else if (op == T_BEQ || op == T_BNE) begin
            v.alu_b = 2'd0; v.alu_op = 3'd1; v.pc_src = 2'd1; v.done = 1'b1;
            v.pc_we = (op == T_BEQ) ? z : !z;
        end else if (op == T_SLTI) begin
            v.alu_op = 3'd3;
        end else if (op == T_LUI) begin
            v.alu_op = 3'd4;
        end
        return v;
    endfunction

    function automatic ovec_t f_mem(input logic is_sw, input logic r);
        ovec_t v = '0;
        v.mem_req = 1'b1; v.iord = 1'b1; v.mem_we = is_sw; v.done = is_sw & r;
        return v;
    endfunction

    function automatic ovec_t f_wb(input logic [5:0] op);
        ovec_t v = '0;
        v.reg_we = 1'b1; v.done = 1'b1;
        v.reg_dst = (op == T_R) ? 2'd1 : 2'd0;
        v.m2r = (op == T_LW) ? 2'd1 : 2'd0;
        return v;
    endfunction

    function automatic ovec_t f_err();
        ovec_t v = '0;
        v.err = 1'b1;
        return v;
    endfunction

    task automatic step(input ovec_t e, input logic [19:0] m, input logic r, input logic rd,
                        input logic [5:0] op, input logic [5:0] fn, input logic z, input string t);
        @(posedge clk);
        #1;
        if (prev_rst) ret_m = '0;
        else if (prev_done) ret_m = ret_m + 1'b1;
        prev_rst  = r;
        prev_done = e.done & !r;
        rst = r; rdy = rd; opcode = op; funct = fn; zero = z;
        exp_v = e; mask = m; exp_ret = ret_m; tag = t; chk_en = 1'b1;
        ncyc++;
        #3;
        if (ncyc < 32) begin
            snap[ncyc]     = act_v;
            snap_ret[ncyc] = retired;
        end
    endtask

    task automatic do_reset(input int n);
        ncyc = 0;
        for (int i = 0; i < n; i++) step('0, M_ALL, 1'b1, r1(), r6(), r6(), r1(), "reset");
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, output int n);
        int k;
        k = klass(op, fn);
        ncyc = 0;
        for (int i = 0; i < fw; i++) step(f_fetch(1'b0), M_ALL, 1'b0, 1'b0, r6(), r6(), r1(), "fetch");
        step(f_fetch(1'b1), M_ALL, 1'b0, 1'b1, r6(), r6(), r1(), "fetch");
        step(f_decode(op, fn), M_ALL, 1'b0, r1(), op, fn, r1(), "decode");
        if (k == K_ILL) begin
            for (int i = 0; i < 3; i++) step(f_err(), M_ALL, 1'b0, r1(), op, fn, r1(), "err");
        end else if (k != K_JMP) begin
            step(f_exec(op, z), M_ALL, 1'b0, r1(), op, fn, z, "exec");
            if (k == K_SW || k == K_LW) begin
                for (int i = 0; i < mw; i++)
                    step(f_mem(k == K_SW, 1'b0), M_NOALU, 1'b0, 1'b0, op, fn, r1(), "mem");
                step(f_mem(k == K_SW, 1'b1), M_NOALU, 1'b0, 1'b1, op, fn, r1(), "mem");
            end
            if (k == K_ALU || k == K_LW) step(f_wb(op), M_NOALU, 1'b0, r1(), op, fn, r1(), "wb");
        end
        n = ncyc;
    endtask

    logic [5:0] ops [0:12] = '{T_R, T_R, T_R, T_R, T_J, T_JAL, T_BEQ, T_BNE, T_ADDI, T_SLTI, T_LUI, T_LW, T_SW};
    logic [5:0] fns [0:12] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, c1, c2, idx, fw, mw, k;

        do_reset(2);
        check_lit("reset_retired", int'(snap_ret[2]), 0);
        check_lit("reset_mem_req", int'(snap[2].mem_req), 0);

        run_instr(T_R, 6'h20, 1'b0, 0, 0, n);
        check_lit("add_cycles", n, 4);
        check_lit("add_c4_reg_we", int'(snap[4].reg_we), 1);
        check_lit("add_c4_reg_dst", int'(snap[4].reg_dst), 1);
        c1 = 0;
        for (int i = 1; i <= n; i++) c1 += int'(snap[i].done);
        check_lit("add_done_count", c1, 1);

        run_instr(T_J, r6(), 1'b0, 0, 0, n);
        check_lit("j_cycles", n, 2);
        check_lit("retired_after_add", int'(snap_ret[1]), 1);

        run_instr(T_LW, r6(), 1'b0, 3, 2, n);
        check_lit("lw_cycles", n, 10);
        c1 = 0; c2 = 0;
        for (int i = 1; i <= n; i++) begin
            c1 += int'(snap[i].ir_we);
            c2 += int'(snap[i].reg_we);
        end
        check_lit("lw_ir_we_count", c1, 1);
        check_lit("lw_reg_we_count", c2, 1);
        check_lit("lw_mem_to_reg", int'(snap[10].m2r), 1);

        run_instr(T_BEQ, r6(), 1'b1, 0, 0, n);
        check_lit("beq_c3_pc_we", int'(snap[3].pc_we), 1);
        check_lit("beq_c3_pc_src", int'(snap[3].pc_src), 1);
        run_instr(T_BNE, r6(), 1'b1, 0, 0, n);
        check_lit("bne_c3_pc_we", int'(snap[3].pc_we), 0);
        check_lit("bne_c3_done", int'(snap[3].done), 1);

        run_instr(T_JAL, r6(), 1'b0, 0, 0, n);
        check_lit("jal_pc_src", int'(snap[2].pc_src), 2);
        check_lit("jal_reg_dst", int'(snap[2].reg_dst), 2);
        check_lit("jal_mem_to_reg", int'(snap[2].m2r), 2);
        check_lit("jal_reg_we", int'(snap[2].reg_we), 1);
        run_instr(T_R, 6'h08, 1'b0, 0, 0, n);
        check_lit("jr_pc_src", int'(snap[2].pc_src), 3);
        check_lit("jr_reg_we", int'(snap[2].reg_we), 0);

        run_instr(T_ADDI, r6(), 1'b0, MT, 0, n);
        check_lit("fetch_rdy_at_limit_cycles", n, 8);

        for (int t = 0; t < 60; t++) begin
            idx = $urandom_range(0, 12);
            fw  = $urandom_range(0, MT);
            mw  = $urandom_range(0, MT);
            k   = klass(ops[idx], fns[idx]);
            run_instr(ops[idx], (ops[idx] == T_R) ? fns[idx] : r6(), r1(), fw, mw, n);
            check_lit("rand_latency", n, base_lat(k) + fw + ((k == K_SW || k == K_LW) ? mw : 0));
        end

        run_instr(T_J, r6(), 1'b0, 0, 0, n);
        if (ret_m == 0) run_instr(T_J, r6(), 1'b0, 0, 0, n);
        ncyc = 0;
        step(f_fetch(1'b1), M_ALL, 1'b0, 1'b1, r6(), r6(), r1(), "fetch");
        step(f_decode(T_SW, 6'h00), M_ALL, 1'b0, 1'b0, T_SW, 6'h00, r1(), "decode");
        step(f_exec(T_SW, 1'b0), M_ALL, 1'b0, 1'b0, T_SW, 6'h00, 1'b0, "exec");
        step(f_mem(1'b1, 1'b0), M_NOALU, 1'b0, 1'b0, T_SW, 6'h00, 1'b0, "mem");
        step('0, M_ALL, 1'b1, 1'b1, T_SW, 6'h00, 1'b0, "rst_mid_mem");
        step(f_fetch(1'b0), M_ALL, 1'b0, 1'b0, r6(), r6(), r1(), "fetch_after_rst");
        check_lit("rst_mid_mem_we", int'(snap[5].mem_we), 0);
        check_lit("rst_mid_retired", int'(snap_ret[6]), 0);
        check_lit("rst_mid_fetch_req", int'(snap[6].mem_req), 1);
        do_reset(1);

        ncyc = 0;
        step(f_fetch(1'b1), M_ALL, 1'b0, 1'b1, r6(), r6(), r1(), "fetch");
        step(f_decode(T_SW, 6'h00), M_ALL, 1'b0, 1'b0, T_SW, 6'h00, r1(), "decode");
        step(f_exec(T_SW, 1'b0), M_ALL, 1'b0, 1'b0, T_SW, 6'h00, 1'b0, "exec");
        for (int i = 0; i <= MT; i++) step(f_mem(1'b1, 1'b0), M_NOALU, 1'b0, 1'b0, T_SW, 6'h00, r1(), "mem_wait");
        for (int i = 0; i < 3; i++) step(f_err(), M_ALL, 1'b0, r1(), T_SW, 6'h00, r1(), "mem_timeout_err");
        check_lit("mem_timeout_pre", int'(snap[8].err), 0);
        check_lit("mem_timeout_err", int'(snap[9].err), 1);
        do_reset(2);

        ncyc = 0;
        for (int i = 0; i <= MT; i++) step(f_fetch(1'b0), M_ALL, 1'b0, 1'b0, r6(), r6(), r1(), "fetch_wait");
        for (int i = 0; i < 4; i++) step(f_err(), M_ALL, 1'b0, r1(), r6(), r6(), r1(), "fetch_timeout_err");
        check_lit("fetch_timeout_pre", int'(snap[5].err), 0);
        check_lit("fetch_timeout_err", int'(snap[6].err), 1);
        check_lit("fetch_timeout_req", int'(snap[9].mem_req), 0);
        do_reset(2);

        run_instr(6'h3F, r6(), 1'b0, 0, 0, n);
        check_lit("illegal_err", int'(snap[3].err), 1);
        do_reset(2);
        run_instr(T_SW, r6(), 1'b0, 0, 0, n);
        check_lit("sw_after_recover_cycles", n, 4);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
